// File: rtl/daq_run_sequencer.sv
// Run-level scheduler for the slave DAQ: arms the slave, issues AcqStart triggers, counts acquisitions, closes the run.
// Optional acquisition/stop watchdog enabled by defining TRIG_TIMEOUT_EN.
module daq_run_sequencer #(
  parameter int unsigned ARM_DELAY      = 64,
  parameter int unsigned TRIG_WIDTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 2**20
) (
  input  logic        Clk,
  input  logic        reset_n,
  input  logic        RunStart,
  input  logic        RunStop,
  input  logic [15:0] RunCount,
  input  logic [15:0] TrigPeriod,
  input  logic        ExtTrigSel,
  input  logic        ExtTrig,
  input  logic        OnceEnd,
  input  logic        AllDone,
  output logic        ModuleStart,
  output logic        AcqStart,
  output logic [15:0] AcqCounter,
  output logic        RunBusy,
  output logic        RunDone,
  output logic        TimeoutErr
);

  // Counter must hold every delay parameter and the full 16-bit trigger period.
  localparam int unsigned MAX_A   = (ARM_DELAY > TRIG_WIDTH) ? ARM_DELAY : TRIG_WIDTH;
  localparam int unsigned MAX_B   = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
  localparam int unsigned MAX_CNT = (MAX_B > 65536) ? MAX_B : 65536;
  localparam int unsigned CNT_W   = $clog2(MAX_CNT) + 1;
  localparam int unsigned NSYNC   = 4;

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_TRIG_WAIT, S_TRIG_PULSE, S_WAIT_ONCE, S_WAIT_ONCE_LOW, S_STOPPING, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [15:0]        acq_cnt_q, acq_cnt_d;
  logic               stop_req_q, stop_req_d;
  logic               ext_sel_q, ext_sel_d;
  logic               module_start_q, module_start_d;
  logic               acq_start_q, acq_start_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [NSYNC-1:0]   sync1_q, sync2_q, prev_q;
  logic [NSYNC-1:0]   rise_c;
  logic               stop_c;

  // Bit order: 0 RunStart, 1 ExtTrig, 2 OnceEnd, 3 AllDone.
  assign rise_c = sync2_q & ~prev_q;
  assign stop_c = stop_req_q | RunStop;

`ifdef TRIG_TIMEOUT_EN
  logic timeout_q, timeout_d;
  logic wd_hit_c;
  assign wd_hit_c = (cnt_q + CNT_W'(1)) >= CNT_W'(TIMEOUT_CYCLES);
`endif

  always_comb begin
    state_d    = state_q;
    acq_cnt_d  = acq_cnt_q;
    stop_req_d = stop_req_q;
    ext_sel_d  = ext_sel_q;
`ifdef TRIG_TIMEOUT_EN
    timeout_d  = timeout_q;
`endif
    if (state_q != S_IDLE && RunStop) stop_req_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        stop_req_d = 1'b0;
        if (rise_c[0]) begin
          state_d   = S_ARM;
          acq_cnt_d = '0;
          ext_sel_d = ExtTrigSel;
`ifdef TRIG_TIMEOUT_EN
          timeout_d = 1'b0;
`endif
        end
      end
      S_ARM: begin
        if ((cnt_q + CNT_W'(1)) >= CNT_W'(ARM_DELAY)) state_d = S_TRIG_WAIT;
      end
      S_TRIG_WAIT: begin
        // A pending stop beats a trigger arriving in the same cycle.
        if (stop_c)                                            state_d = S_STOPPING;
        else if (ext_sel_q ? rise_c[1] : (cnt_q >= CNT_W'(TrigPeriod))) state_d = S_TRIG_PULSE;
      end
      S_TRIG_PULSE: begin
        if ((cnt_q + CNT_W'(1)) >= CNT_W'(TRIG_WIDTH)) state_d = S_WAIT_ONCE;
      end
      S_WAIT_ONCE: begin
        if (rise_c[2]) begin
          acq_cnt_d = acq_cnt_q + 16'd1;
          state_d   = S_WAIT_ONCE_LOW;
        end
`ifdef TRIG_TIMEOUT_EN
        else if (wd_hit_c) begin
          timeout_d = 1'b1;
          state_d   = S_STOPPING;
        end
`endif
      end
      S_WAIT_ONCE_LOW: begin
        if (!sync2_q[2]) begin
          if (stop_c || (RunCount != 16'd0 && acq_cnt_q == RunCount)) state_d = S_STOPPING;
          else                                                       state_d = S_TRIG_WAIT;
        end
      end
      S_STOPPING: begin
        if (rise_c[3]) state_d = S_DONE;
`ifdef TRIG_TIMEOUT_EN
        else if (wd_hit_c) begin
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end
`endif
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    cnt_d          = (state_d != state_q) ? '0 : cnt_q + CNT_W'(1);
    module_start_d = (state_d == S_ARM) || (state_d == S_TRIG_WAIT) || (state_d == S_TRIG_PULSE) ||
                     (state_d == S_WAIT_ONCE) || (state_d == S_WAIT_ONCE_LOW);
    acq_start_d    = (state_d == S_TRIG_PULSE);
    busy_d         = (state_d != S_IDLE);
    done_d         = (state_d == S_DONE);
  end

  // Outputs are decoded from the next state so every one is a flop output.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      acq_cnt_q      <= '0;
      stop_req_q     <= 1'b0;
      ext_sel_q      <= 1'b0;
      module_start_q <= 1'b0;
      acq_start_q    <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      sync1_q        <= '0;
      sync2_q        <= '0;
      prev_q         <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      acq_cnt_q      <= acq_cnt_d;
      stop_req_q     <= stop_req_d;
      ext_sel_q      <= ext_sel_d;
      module_start_q <= module_start_d;
      acq_start_q    <= acq_start_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      sync1_q        <= {AllDone, OnceEnd, ExtTrig, RunStart};
      sync2_q        <= sync1_q;
      prev_q         <= sync2_q;
    end
  end

`ifdef TRIG_TIMEOUT_EN
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) timeout_q <= 1'b0;
    else          timeout_q <= timeout_d;
  end
  assign TimeoutErr = timeout_q;
`else
  assign TimeoutErr = 1'b0;
`endif

  assign ModuleStart = module_start_q;
  assign AcqStart    = acq_start_q;
  assign AcqCounter  = acq_cnt_q;
  assign RunBusy     = busy_q;
  assign RunDone     = done_q;

endmodule

// File: tb/tb_daq_run_sequencer.sv
// Directed bench for daq_run_sequencer with a behavioural slave DAQ responder.
// Watchdog scenario is compiled only when TRIG_TIMEOUT_EN is defined.
module tb_daq_run_sequencer;

  logic        Clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        RunStart = 1'b0, RunStop = 1'b0, ExtTrigSel = 1'b0, ExtTrig = 1'b0;
  logic        OnceEnd = 1'b0, AllDone = 1'b0;
  logic [15:0] RunCount = 16'd0, TrigPeriod = 16'd0;
  logic        ModuleStart, AcqStart, RunBusy, RunDone, TimeoutErr;
  logic [15:0] AcqCounter;

  int n_checks = 0, n_pass = 0;
  int once_delay = 500;
  bit once_en = 1'b0, done_en = 1'b0;
  int acq_pulses = 0, bad_width = 0, done_pulses = 0, width = 0;

  always #5 Clk = ~Clk;

  daq_run_sequencer #(.ARM_DELAY(64), .TRIG_WIDTH(4), .TIMEOUT_CYCLES(1000)) dut (
    .Clk(Clk), .reset_n(reset_n), .RunStart(RunStart), .RunStop(RunStop),
    .RunCount(RunCount), .TrigPeriod(TrigPeriod), .ExtTrigSel(ExtTrigSel), .ExtTrig(ExtTrig),
    .OnceEnd(OnceEnd), .AllDone(AllDone), .ModuleStart(ModuleStart), .AcqStart(AcqStart),
    .AcqCounter(AcqCounter), .RunBusy(RunBusy), .RunDone(RunDone), .TimeoutErr(TimeoutErr)
  );

  // Slave: OnceEnd pulse a fixed delay after each trigger.
  initial forever begin
    @(posedge AcqStart);
    repeat (once_delay) @(posedge Clk);
    #1;
    if (once_en) begin
      OnceEnd = 1'b1;
      repeat (10) @(posedge Clk);
      #1 OnceEnd = 1'b0;
    end
  end

  // Slave: AllDone pulse after the module is disabled.
  initial forever begin
    @(negedge ModuleStart);
    if (done_en) begin
      repeat (5) @(posedge Clk);
      #1 AllDone = 1'b1;
      repeat (10) @(posedge Clk);
      #1 AllDone = 1'b0;
    end
  end

  // Pulse monitor: counts AcqStart pulses, off-width pulses and RunDone cycles.
  always @(negedge Clk) begin
    if (RunDone === 1'b1) done_pulses <= done_pulses + 1;
    if (AcqStart === 1'b1) width <= width + 1;
    else if (width != 0) begin
      acq_pulses <= acq_pulses + 1;
      if (width != 4) bad_width <= bad_width + 1;
      width <= 0;
    end
  end

  function automatic logic sel(input int which);
    case (which)
      0: sel = AcqStart;
      1: sel = RunDone;
      2: sel = OnceEnd;
      3: sel = ModuleStart;
      default: sel = TimeoutErr;
    endcase
  endfunction

  // Returns cycles until the selected signal equals val, or -1 on budget expiry.
  task automatic wait_for(input int which, input logic val, input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      @(posedge Clk); #1;
      if (sel(which) === val) begin n = i; break; end
    end
  endtask

  task automatic start_run();
    RunStart = 1'b0;
    repeat (5) @(posedge Clk);
    #1 RunStart = 1'b1;
  endtask

  task automatic ext_pulse();
    ExtTrig = 1'b1;
    repeat (3) @(posedge Clk);
    #1 ExtTrig = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    n_checks++; if ({ModuleStart, AcqStart, RunBusy, RunDone, TimeoutErr, AcqCounter} !== 21'd0)
      $display("FAIL reset_outputs: got %b want all zero", {ModuleStart, AcqStart, RunBusy, RunDone, TimeoutErr, AcqCounter}); else n_pass++;
    reset_n = 1'b1;
    repeat (5) @(posedge Clk);
    #1;
    n_checks++; if (RunBusy !== 1'b0) $display("FAIL reset_idle: RunBusy=%b want 0", RunBusy); else n_pass++;
  endtask

  task automatic test_internal();
    int n, p0, d0, b0;
    RunCount = 16'd3; TrigPeriod = 16'd100; ExtTrigSel = 1'b0;
    once_delay = 500; once_en = 1'b1; done_en = 1'b1;
    p0 = acq_pulses; d0 = done_pulses; b0 = bad_width;
    @(posedge Clk); #1 RunStart = 1'b1;
    wait_for(0, 1'b1, 400, n);
    n_checks++; if (n < 164 || n > 170) $display("FAIL int_first_trig: latency=%0d want 164..170", n); else n_pass++;
    wait_for(1, 1'b1, 5000, n);
    n_checks++; if (n < 0) $display("FAIL int_rundone: timed out got %0d want RunDone", n); else n_pass++;
    n_checks++; if (ModuleStart !== 1'b0) $display("FAIL int_modstart: got %b want 0", ModuleStart); else n_pass++;
    n_checks++; if (AcqCounter !== 16'd3) $display("FAIL int_count: got %0d want 3", AcqCounter); else n_pass++;
    repeat (20) @(posedge Clk);
    #1;
    n_checks++; if (acq_pulses - p0 != 3) $display("FAIL int_pulses: got %0d want 3", acq_pulses - p0); else n_pass++;
    n_checks++; if (bad_width != b0) $display("FAIL int_width: bad widths %0d want 0", bad_width - b0); else n_pass++;
    n_checks++; if (done_pulses - d0 != 1) $display("FAIL int_done_once: got %0d want 1", done_pulses - d0); else n_pass++;
    n_checks++; if ({RunBusy, TimeoutErr} !== 2'b00) $display("FAIL int_idle: busy/terr=%b want 00", {RunBusy, TimeoutErr}); else n_pass++;
    RunStart = 1'b0;
  endtask

  task automatic test_external();
    int n, p0, d0;
    RunCount = 16'd0; ExtTrigSel = 1'b1; once_delay = 100; once_en = 1'b1; done_en = 1'b1;
    p0 = acq_pulses; d0 = done_pulses;
    start_run();
    repeat (80) @(posedge Clk);
    #1;
    ext_pulse();
    repeat (14) @(posedge Clk); #1;
    ext_pulse();
    repeat (14) @(posedge Clk); #1;
    ext_pulse();
    n_checks++; if (acq_pulses - p0 != 1) $display("FAIL ext_ignored_busy: pulses=%0d want 1", acq_pulses - p0); else n_pass++;
    repeat (200) @(posedge Clk); #1;
    ext_pulse();
    repeat (200) @(posedge Clk); #1;
    ext_pulse();
    repeat (200) @(posedge Clk); #1;
    RunStop = 1'b1;
    repeat (2) @(posedge Clk);
    #1 RunStop = 1'b0;
    wait_for(1, 1'b1, 200, n);
    n_checks++; if (n < 0) $display("FAIL ext_rundone: timed out got %0d want RunDone", n); else n_pass++;
    repeat (5) @(posedge Clk); #1;
    n_checks++; if (acq_pulses - p0 != 3) $display("FAIL ext_pulses: got %0d want 3", acq_pulses - p0); else n_pass++;
    n_checks++; if (AcqCounter !== 16'd3) $display("FAIL ext_count: got %0d want 3", AcqCounter); else n_pass++;
    n_checks++; if (done_pulses - d0 != 1) $display("FAIL ext_done_once: got %0d want 1", done_pulses - d0); else n_pass++;
    RunStart = 1'b0;
  endtask

  task automatic test_stop_fire();
    int n, p0;
    RunCount = 16'd0; TrigPeriod = 16'd10; ExtTrigSel = 1'b0; once_en = 1'b1; done_en = 1'b1;
    p0 = acq_pulses;
    @(posedge Clk); #1 RunStart = 1'b0;
    repeat (5) @(posedge Clk);
    #1 RunStart = 1'b1;
    repeat (77) @(posedge Clk);
    #1 RunStop = 1'b1;
    @(posedge Clk);
    #1 RunStop = 1'b0;
    n_checks++; if (AcqStart !== 1'b0) $display("FAIL sf_no_trig: AcqStart=%b want 0", AcqStart); else n_pass++;
    n_checks++; if ({ModuleStart, RunBusy} !== 2'b01) $display("FAIL sf_stopping: mod/busy=%b want 01", {ModuleStart, RunBusy}); else n_pass++;
    wait_for(1, 1'b1, 100, n);
    n_checks++; if (n < 0) $display("FAIL sf_rundone: timed out got %0d want RunDone", n); else n_pass++;
    repeat (5) @(posedge Clk); #1;
    n_checks++; if (acq_pulses - p0 != 0 || AcqCounter !== 16'd0)
      $display("FAIL sf_zero_acq: pulses=%0d count=%0d want 0/0", acq_pulses - p0, AcqCounter); else n_pass++;
    RunStart = 1'b0;
  endtask

  task automatic test_stop_wait_once();
    int n, p0;
    RunCount = 16'd0; TrigPeriod = 16'd5; ExtTrigSel = 1'b0; once_delay = 60; once_en = 1'b1; done_en = 1'b1;
    p0 = acq_pulses;
    start_run();
    wait_for(0, 1'b1, 200, n);
    n_checks++; if (n < 0) $display("FAIL swo_trig: timed out got %0d want AcqStart", n); else n_pass++;
    repeat (20) @(posedge Clk);
    #1 RunStop = 1'b1;
    repeat (2) @(posedge Clk);
    #1 RunStop = 1'b0;
    n_checks++; if ({ModuleStart, AcqCounter} !== {1'b1, 16'd0}) $display("FAIL swo_inflight: mod=%b count=%0d want 1/0", ModuleStart, AcqCounter); else n_pass++;
    wait_for(2, 1'b0, 100, n);
    wait_for(2, 1'b1, 100, n);
    wait_for(2, 1'b0, 50, n);
    n_checks++; if (n < 0 || ModuleStart !== 1'b1) $display("FAIL swo_hold: n=%0d mod=%b want mod 1 at OnceEnd fall", n, ModuleStart); else n_pass++;
    wait_for(3, 1'b0, 10, n);
    n_checks++; if (n < 0) $display("FAIL swo_modfall: timed out got %0d want ModuleStart 0", n); else n_pass++;
    n_checks++; if (AcqCounter !== 16'd1) $display("FAIL swo_count: got %0d want 1", AcqCounter); else n_pass++;
    wait_for(1, 1'b1, 100, n);
    repeat (20) @(posedge Clk); #1;
    n_checks++; if (n < 0 || acq_pulses - p0 != 1) $display("FAIL swo_pulses: n=%0d pulses=%0d want 1", n, acq_pulses - p0); else n_pass++;
    RunStart = 1'b0;
  endtask

`ifdef TRIG_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    RunCount = 16'd0; TrigPeriod = 16'd0; ExtTrigSel = 1'b0; once_en = 1'b0; done_en = 1'b0;
    start_run();
    wait_for(0, 1'b1, 200, n);
    wait_for(0, 1'b0, 10, n);
    wait_for(4, 1'b1, 1100, n);
    n_checks++; if (n < 999 || n > 1001) $display("FAIL to_latency: got %0d want 999..1001", n); else n_pass++;
    n_checks++; if ({ModuleStart, AcqCounter} !== 17'd0) $display("FAIL to_state: mod=%b count=%0d want 0/0", ModuleStart, AcqCounter); else n_pass++;
    wait_for(1, 1'b1, 1100, n);
    n_checks++; if (n < 0) $display("FAIL to_rundone: timed out got %0d want RunDone", n); else n_pass++;
    repeat (5) @(posedge Clk); #1;
    n_checks++; if ({TimeoutErr, RunBusy} !== 2'b10) $display("FAIL to_sticky: terr/busy=%b want 10", {TimeoutErr, RunBusy}); else n_pass++;
    RunStart = 1'b0;
  endtask
`endif

  task automatic test_reset_mid();
    int n;
    RunCount = 16'd0; TrigPeriod = 16'd0; ExtTrigSel = 1'b0; once_delay = 30; once_en = 1'b1; done_en = 1'b0;
    start_run();
    wait_for(0, 1'b1, 200, n);
    wait_for(0, 1'b0, 10, n);
    wait_for(0, 1'b1, 200, n);
    n_checks++; if (n < 0 || AcqCounter !== 16'd1) $display("FAIL rm_second: n=%0d count=%0d want count 1", n, AcqCounter); else n_pass++;
    @(posedge Clk);
    #1 once_en = 1'b0; RunStart = 1'b0; reset_n = 1'b0;
    #1;
    n_checks++; if ({AcqStart, ModuleStart, RunBusy, AcqCounter} !== 19'd0)
      $display("FAIL rm_async: acq/mod/busy=%b count=%0d want 0", {AcqStart, ModuleStart, RunBusy}, AcqCounter); else n_pass++;
    repeat (3) @(posedge Clk);
    #1 reset_n = 1'b1;
    repeat (10) @(posedge Clk); #1;
    n_checks++; if ({RunBusy, ModuleStart, AcqCounter} !== 18'd0)
      $display("FAIL rm_idle: busy/mod=%b count=%0d want 0", {RunBusy, ModuleStart}, AcqCounter); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_internal();
    test_external();
    test_stop_fire();
    test_stop_wait_once();
`ifdef TRIG_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
